mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max wait cycles for mem_ready per access; 0 disables timeout.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go  input  1  run enable, sampled in IDLE and at instruction retire.
REQ-006 opcode  input  7  instruction bits [6:0].
REQ-007 func3  input  3  instruction bits [14:12].
REQ-008 func7  input  7  instruction bits [31:25].
REQ-009 comp  input  1  datapath branch-taken flag, valid in EXEC.
REQ-010 mem_ready  input  1  memory completes current access this cycle.
REQ-011 irEn  output  1  load instruction register.
REQ-012 pcEn  output  1  update PC.
REQ-013 pc_select  output  2  00 PC+4, 01 PC+imm, 10 rs1+imm.
REQ-014 aluSrc  output  1  0 ALU operand B = rs2, 1 = immediate.
REQ-015 regWrite  output  1  register file write strobe.
REQ-016 memToReg  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-017 mem_size  output  2  00 byte, 01 half, 10 word.
REQ-018 memRead  output  1  memory read request, held until mem_ready.
REQ-019 memWrite  output  1  memory write request, held until mem_ready.
REQ-020 halt_cause  output  2  00 none, 01 ECALL/EBREAK, 10 illegal instruction, 11 memory timeout.
REQ-021 cycle_cnt  output  CNT_W  active-cycle counter.
REQ-022 instret_cnt  output  CNT_W  retired-instruction counter.

Function
REQ-023 States IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; every output not named for a state SHALL be 0 in that state.
REQ-024 IDLE: go=1 -> FETCH next cycle; otherwise stay.
REQ-025 FETCH: memRead=1, mem_size=10; in the mem_ready=1 cycle irEn=1 and next state is DECODE; otherwise stay.
REQ-026 DECODE: legal opcodes 0110011 (func7 must be 0000000 or 0100000), 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC; 1110011 -> HALT, cause 01; any other -> HALT, cause 10.
REQ-027 EXEC: aluSrc=0 for 0110011 and 1100011, else 1; loads/stores -> MEM; branch: pcEn=1, pc_select=comp?01:00, retire; all others -> WB.
REQ-028 MEM: mem_size=func3[1:0]; memRead (load) or memWrite (store) held until mem_ready=1; load -> WB; store: pcEn=1, pc_select=00, retire in the ready cycle.
REQ-029 WB: regWrite=1, pcEn=1, retire; memToReg 01 for loads, 10 for JAL/JALR, else 00; pc_select 01 for JAL, 10 for JALR, else 00.
REQ-030 Retire: next state FETCH if go=1, IDLE if go=0.
REQ-031 Timeout: wait counter clears on entry to FETCH/MEM and counts cycles with mem_ready=0; reaching MEM_TIMEOUT -> HALT, cause 11, no strobe issued; mem_ready in the same cycle wins.
REQ-032 HALT: all strobes 0, halt_cause held; exit only by reset.

Reset
REQ-033 reset=1 at any edge, including mid-access, SHALL force IDLE, all outputs 0, halt_cause 00, counters 0; reset dominates go and mem_ready.

Configuration
REQ-034 With PERF_CNT_EN defined: cycle_cnt increments each cycle outside IDLE/HALT, instret_cnt increments each retire; both wrap modulo 2^CNT_W.
REQ-035 Without PERF_CNT_EN: counter logic is not built; cycle_cnt and instret_cnt are constant 0.

Verification
REQ-036 go=1, ADD (opcode 0110011, func7 0) with mem_ready always 1 -> retire 4 cycles after FETCH entry; regWrite=1 in WB; instret_cnt=1.
REQ-037 LW with mem_ready delayed 3 cycles in MEM -> memRead held 4 cycles, mem_size=10, memToReg=01 in WB.
REQ-038 BEQ with comp=1 -> EXEC pcEn=1, pc_select=01; comp=0 -> pc_select=00; no regWrite.
REQ-039 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles, halt_cause=11, irEn never asserted.
REQ-040 Opcode 1111111 -> halt_cause=10; reset asserted during a MEM wait -> IDLE next cycle, memRead=0, counters 0.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM (fetch/decode/exec/mem/writeback) with memory wait timeout.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters; otherwise both read 0.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             comp,
    input  logic             mem_ready,
    output logic             irEn,
    output logic             pcEn,
    output logic [1:0]       pc_select,
    output logic             aluSrc,
    output logic             regWrite,
    output logic [1:0]       memToReg,
    output logic [1:0]       mem_size,
    output logic             memRead,
    output logic             memWrite,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // A timeout of 0 disables the wait counter; width is kept at least one bit.
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int                WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_r;
    logic [2:0]        stepState_s;
    logic [2:0]        nextState_s;
    logic [1:0]        haltCause_r;
    logic [1:0]        nextCause_s;
    logic [WAIT_W-1:0] waitCnt_r;
    logic              retire_s;
    logic              memTimeout_s;
    logic              unusedFunc3_s;

    logic isOp_s, isImm_s, isLoad_s, isStore_s, isBranch_s, isJal_s, isJalr_s;
    logic isLui_s, isAuipc_s, isSystem_s, legal_s;

    assign isOp_s     = (opcode == OP_R);
    assign isImm_s    = (opcode == OP_IMM);
    assign isLoad_s   = (opcode == OP_LOAD);
    assign isStore_s  = (opcode == OP_STORE);
    assign isBranch_s = (opcode == OP_BRANCH);
    assign isJal_s    = (opcode == OP_JAL);
    assign isJalr_s   = (opcode == OP_JALR);
    assign isLui_s    = (opcode == OP_LUI);
    assign isAuipc_s  = (opcode == OP_AUIPC);
    assign isSystem_s = (opcode == OP_SYSTEM);

    // Register-register ops are only legal with the base or alternate func7 encoding.
    assign legal_s = (isOp_s && ((func7 == 7'b0000000) || (func7 == 7'b0100000)))
                   || isImm_s || isLoad_s || isStore_s || isBranch_s
                   || isJal_s || isJalr_s || isLui_s || isAuipc_s;

    // A ready in the final allowed wait cycle still completes the access.
    assign memTimeout_s  = TIMEOUT_EN && !mem_ready && (waitCnt_r == WAIT_LAST);
    assign halt_cause    = haltCause_r;
    assign unusedFunc3_s = &{1'b0, func3[2]};

    // Next-state and control-strobe decode.
    always_comb begin
        stepState_s = state_r;
        nextCause_s = haltCause_r;
        retire_s    = 1'b0;
        irEn        = 1'b0;
        pcEn        = 1'b0;
        pc_select   = 2'b00;
        aluSrc      = 1'b0;
        regWrite    = 1'b0;
        memToReg    = 2'b00;
        mem_size    = 2'b00;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    stepState_s = S_FETCH;
                end else begin
                    stepState_s = S_IDLE;
                end
            end
            S_FETCH: begin
                memRead  = 1'b1;
                mem_size = 2'b10;
                if (mem_ready) begin
                    irEn        = 1'b1;
                    stepState_s = S_DECODE;
                end else if (memTimeout_s) begin
                    stepState_s = S_HALT;
                    nextCause_s = CAUSE_TIMEOUT;
                end else begin
                    stepState_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    stepState_s = S_EXEC;
                end else if (isSystem_s) begin
                    stepState_s = S_HALT;
                    nextCause_s = CAUSE_SYSTEM;
                end else begin
                    stepState_s = S_HALT;
                    nextCause_s = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                aluSrc = !(isOp_s || isBranch_s);
                if (isLoad_s || isStore_s) begin
                    stepState_s = S_MEM;
                end else if (isBranch_s) begin
                    pcEn      = 1'b1;
                    pc_select = comp ? 2'b01 : 2'b00;
                    retire_s  = 1'b1;
                end else begin
                    stepState_s = S_WB;
                end
            end
            S_MEM: begin
                mem_size = func3[1:0];
                memRead  = isLoad_s;
                memWrite = isStore_s;
                if (mem_ready) begin
                    if (isLoad_s) begin
                        stepState_s = S_WB;
                    end else begin
                        pcEn     = 1'b1;
                        retire_s = 1'b1;
                    end
                end else if (memTimeout_s) begin
                    stepState_s = S_HALT;
                    nextCause_s = CAUSE_TIMEOUT;
                end else begin
                    stepState_s = S_MEM;
                end
            end
            S_WB: begin
                regWrite  = 1'b1;
                pcEn      = 1'b1;
                retire_s  = 1'b1;
                memToReg  = isLoad_s ? 2'b01 : ((isJal_s || isJalr_s) ? 2'b10 : 2'b00);
                pc_select = isJal_s ? 2'b01 : (isJalr_s ? 2'b10 : 2'b00);
            end
            S_HALT: begin
                stepState_s = S_HALT;
            end
            default: begin
                stepState_s = S_IDLE;
                nextCause_s = CAUSE_NONE;
            end
        endcase
        nextState_s = retire_s ? (go ? S_FETCH : S_IDLE) : stepState_s;
    end

    // FSM state and latched halt cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            haltCause_r <= CAUSE_NONE;
        end else begin
            state_r     <= nextState_s;
            haltCause_r <= nextCause_s;
        end
    end

    // Memory wait counter: restarts on every state change, counts not-ready cycles in FETCH/MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_r <= {WAIT_W{1'b0}};
        end else if (nextState_s != state_r) begin
            waitCnt_r <= {WAIT_W{1'b0}};
        end else if (TIMEOUT_EN && !mem_ready && ((state_r == S_FETCH) || (state_r == S_MEM))) begin
            waitCnt_r <= waitCnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            waitCnt_r <= waitCnt_r;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycleCnt_r;
    logic [CNT_W-1:0] instretCnt_r;

    // Active-cycle and retire counters, wrapping naturally at CNT_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCnt_r   <= {CNT_W{1'b0}};
            instretCnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r != S_IDLE) && (state_r != S_HALT)) begin
                cycleCnt_r <= cycleCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cycleCnt_r <= cycleCnt_r;
            end
            if (retire_s) begin
                instretCnt_r <= instretCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instretCnt_r <= instretCnt_r;
            end
        end
    end

    assign cycle_cnt   = cycleCnt_r;
    assign instret_cnt = instretCnt_r;
`else
    assign cycle_cnt   = {CNT_W{1'b0}};
    assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4): instruction flows, halts, timeout and reset.
module tb_mc_controller;

    localparam int CW = 8;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, go, comp, mem_ready;
    logic [6:0]    opcode, func7;
    logic [2:0]    func3;
    logic          irEn, pcEn, aluSrc, regWrite, memRead, memWrite;
    logic [1:0]    pc_select, memToReg, mem_size, halt_cause;
    logic [CW-1:0] cycle_cnt, instret_cnt;
    logic [13:0]   obs;
    int            vecs = 0;
    int            errs = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .go(go), .opcode(opcode), .func3(func3), .func7(func7),
        .comp(comp), .mem_ready(mem_ready), .irEn(irEn), .pcEn(pcEn), .pc_select(pc_select),
        .aluSrc(aluSrc), .regWrite(regWrite), .memToReg(memToReg), .mem_size(mem_size),
        .memRead(memRead), .memWrite(memWrite), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign obs = {irEn, pcEn, pc_select, aluSrc, regWrite, memToReg, mem_size, memRead, memWrite, halt_cause};

    // Expected output word, in the same field order as obs.
    function automatic logic [13:0] ex(input logic ir, input logic pc, input logic [1:0] pcs,
                                       input logic alu, input logic rw, input logic [1:0] m2r,
                                       input logic [1:0] ms, input logic mr, input logic mw,
                                       input logic [1:0] hc);
        return {ir, pc, pcs, alu, rw, m2r, ms, mr, mw, hc};
    endfunction

    task automatic nextc();
        @(posedge clk);
        #1;
    endtask

    task automatic chkOut(input string tag, input logic [13:0] e);
        #1;
        vecs++;
        assert (obs === e) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b (ir pc pcs alu rw m2r ms mr mw hc)", tag, obs, e);
        end
    endtask

    task automatic chkCnt(input string tag, input logic [CW-1:0] cyc, input logic [CW-1:0] ins);
        vecs++;
        assert ({cycle_cnt, instret_cnt} === {cyc, ins}) else begin
            errs++;
            $error("FAIL %s: observed cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                   tag, cycle_cnt, instret_cnt, cyc, ins);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; go = 1'b0; comp = 1'b0; mem_ready = 1'b0;
        opcode = 7'b0000000; func3 = 3'b000; func7 = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        chkOut("reset_outputs", 14'd0);
        chkCnt("reset_counters", 8'd0, 8'd0);

        // ADD, memory always ready
        reset = 1'b0; go = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        chkOut("idle", 14'd0);
        nextc(); chkOut("add_fetch", ex(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        nextc(); chkOut("add_decode", 14'd0);
        nextc(); chkOut("add_exec", 14'd0);
        nextc(); chkOut("add_wb", ex(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));

        // LW with three not-ready cycles in MEM
        opcode = 7'b0000011; func3 = 3'b010;
        nextc(); chkOut("lw_fetch", ex(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        nextc();
        nextc(); chkOut("lw_exec", ex(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextc(); chkOut("lw_mem_wait", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        end
        nextc(); mem_ready = 1'b1;
        chkOut("lw_mem_ready", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        go = 1'b0;
        nextc(); chkOut("lw_wb", ex(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00));
        nextc(); chkOut("idle_after_lw", 14'd0);
        chkCnt("cnt_after_lw", PERF ? 8'd12 : 8'd0, PERF ? 8'd2 : 8'd0);

        // BEQ taken then not taken
        opcode = 7'b1100011; go = 1'b1; comp = 1'b1;
        nextc(); nextc(); nextc();
        chkOut("beq_taken", ex(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        nextc(); chkOut("beq_refetch", ex(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        nextc(); nextc(); comp = 1'b0;
        chkOut("beq_not_taken", ex(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        go = 1'b0;
        nextc(); chkOut("idle_after_beq", 14'd0);

        // SH completing in the first MEM cycle
        opcode = 7'b0100011; func3 = 3'b001; go = 1'b1;
        nextc(); nextc(); nextc();
        chkOut("sh_exec", ex(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
        nextc(); chkOut("sh_mem", ex(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00));

        // JALR then JAL, back-to-back
        opcode = 7'b1100111;
        nextc(); nextc(); nextc(); nextc();
        chkOut("jalr_wb", ex(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00));
        opcode = 7'b1101111;
        nextc(); nextc(); nextc(); nextc();
        chkOut("jal_wb", ex(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00));
        go = 1'b0;
        nextc(); chkCnt("cnt_after_jal", PERF ? 8'd30 : 8'd0, PERF ? 8'd7 : 8'd0);

        // Illegal opcode halts and holds
        opcode = 7'b1111111; go = 1'b1;
        nextc(); nextc(); chkOut("illegal_decode", 14'd0);
        nextc(); chkOut("illegal_halt", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10));
        repeat (3) nextc();
        chkOut("halt_hold", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10));
        chkCnt("cnt_frozen_in_halt", PERF ? 8'd32 : 8'd0, PERF ? 8'd7 : 8'd0);
        reset = 1'b1;
        nextc(); reset = 1'b0;
        chkOut("reset_from_halt", 14'd0);
        chkCnt("reset_from_halt_cnt", 8'd0, 8'd0);

        // ECALL
        opcode = 7'b1110011; func3 = 3'b000;
        nextc(); nextc(); nextc();
        chkOut("ecall_halt", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01));

        // R-type with unsupported func7
        reset = 1'b1;
        nextc(); reset = 1'b0; opcode = 7'b0110011; func7 = 7'b0000001;
        nextc(); nextc(); nextc();
        chkOut("bad_func7_halt", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10));
        func7 = 7'b0000000;

        // Fetch timeout: four not-ready cycles
        reset = 1'b1;
        nextc(); reset = 1'b0; mem_ready = 1'b0;
        nextc();
        for (int i = 0; i < 4; i++) begin
            chkOut("timeout_fetch_wait", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
            nextc();
        end
        chkOut("fetch_timeout_halt", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11));

        // Reset during a MEM wait
        reset = 1'b1;
        nextc(); reset = 1'b0; mem_ready = 1'b1; opcode = 7'b0000011; func3 = 3'b010;
        nextc(); nextc(); nextc(); mem_ready = 1'b0;
        nextc(); chkOut("lw2_mem_wait", ex(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00));
        nextc(); reset = 1'b1; mem_ready = 1'b1;
        nextc(); chkOut("reset_mid_mem", 14'd0);
        chkCnt("reset_mid_mem_cnt", 8'd0, 8'd0);
        reset = 1'b0; go = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
